// File: rtl/apb_master_multi_slave.sv
// APB master bridging a valid/ready request port to NUM_SLAVES internal register-file slaves.
// Optional macro APB_PSTRB_EN adds the apb_strb byte-strobe port for partial-word writes.
module apb_master_multi_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLV_DEPTH   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    apb_clk,
  input  logic                    apb_reset,
  input  logic                    apb_req_valid,
  output logic                    apb_req_ready,
  input  logic                    apb_wr_rd,
  input  logic [ADDR_WIDTH-1:0]   apb_addr,
  input  logic [DATA_WIDTH-1:0]   apb_wdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] apb_strb,
`endif
  output logic                    apb_rsp_valid,
  output logic [DATA_WIDTH-1:0]   apb_rdata,
  output logic                    apb_slverr
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int SB   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int OFFS = $clog2(NB);
  localparam int IW   = ADDR_WIDTH - SB - OFFS;
  localparam int MW   = (SLV_DEPTH > 1) ? $clog2(SLV_DEPTH) : 1;
  localparam int WW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    pwrite_q;
  logic [NB-1:0]           pstrb_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;
  logic                    accept;

  logic [SB-1:0]           sel;
  logic [IW-1:0]           widx;
  logic [2**SB-1:0]        sel_ok;
  logic                    dec_err;
  logic                    penable;
  logic [NUM_SLAVES-1:0]   psel, pready, pslverr;
  logic [DATA_WIDTH-1:0]   prdata [NUM_SLAVES];
  logic                    pready_m, pslverr_m;
  logic [DATA_WIDTH-1:0]   prdata_m;
  logic                    unused_addr_lsb;

  assign sel             = paddr_q[ADDR_WIDTH-1 -: SB];
  assign widx            = paddr_q[ADDR_WIDTH-SB-1 : OFFS];
  assign unused_addr_lsb = ^paddr_q[OFFS-1:0];

  // Select codes past the last slave decode to nothing and complete with an error.
  for (genvar g = 0; g < 2**SB; g++) begin : g_sel_ok
    assign sel_ok[g] = (g < NUM_SLAVES);
  end
  assign dec_err = !sel_ok[sel];
  assign penable = (state_q == ACCESS);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    apb_req_ready = 1'b0;
    accept        = 1'b0;
    rsp_valid_d   = 1'b0;
    rdata_d       = rdata_q;
    slverr_d      = slverr_q;
    unique case (state_q)
      IDLE: begin
        apb_req_ready = 1'b1;
        if (apb_req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (dec_err || pready_m) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          slverr_d    = dec_err | pslverr_m;
          rdata_d     = (dec_err || pwrite_q) ? '0 : prdata_m;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (apb_reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      slverr_q    <= slverr_d;
      if (accept) begin
        paddr_q  <= apb_addr;
        pwdata_q <= apb_wdata;
        pwrite_q <= apb_wr_rd;
`ifdef APB_PSTRB_EN
        pstrb_q  <= apb_strb;
`else
        pstrb_q  <= '1;
`endif
      end
    end
  end

  assign apb_rsp_valid = rsp_valid_q;
  assign apb_rdata     = rdata_q;
  assign apb_slverr    = slverr_q;

  // Slaves drive zero unless responding, so the return path is a plain OR.
  always_comb begin
    pready_m  = |pready;
    pslverr_m = |pslverr;
    prdata_m  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) prdata_m |= prdata[i];
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
    logic [DATA_WIDTH-1:0] mem_q [SLV_DEPTH];
    logic [WW-1:0]         wait_q;
    logic                  access;
    logic                  in_range;

    assign psel[s]    = (state_q != IDLE) && !dec_err && (sel == SB'(s));
    assign access     = psel[s] && penable;
    assign in_range   = 32'(widx) < SLV_DEPTH;
    assign pready[s]  = access && (wait_q == WW'(WAIT_STATES));
    assign pslverr[s] = pready[s] && !in_range;
    assign prdata[s]  = (pready[s] && in_range && !pwrite_q) ? mem_q[widx[MW-1:0]] : '0;

    always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
        wait_q <= '0;
        // NOTE: storage must read as zero after reset, so the array is cleared here (flops, not a RAM macro).
        for (int k = 0; k < SLV_DEPTH; k++) mem_q[k] <= '0;
      end else begin
        if (pready[s])   wait_q <= '0;
        else if (access) wait_q <= wait_q + 1'b1;
        if (pready[s] && in_range && pwrite_q) begin
          for (int b = 0; b < NB; b++) begin
            if (pstrb_q[b]) mem_q[widx[MW-1:0]][b*8 +: 8] <= pwdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule
